// File: rtl/fetch_pkg.sv
// Shared encodings for the fetch-stage next-PC unit: pc_sel source codes
// and the controller's FSM states.
package fetch_pkg;

  localparam logic [2:0] SEL_PRED   = 3'd0;
  localparam logic [2:0] SEL_JUMP   = 3'd2;
  localparam logic [2:0] SEL_RECOV  = 3'd3;
  localparam logic [2:0] SEL_BHNDLR = 3'd4;
  localparam logic [2:0] SEL_SEQ    = 3'd5;
  localparam logic [2:0] SEL_HOLD   = 3'd6;
  localparam logic [2:0] SEL_RST    = 3'd7;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/lane_prio_enc.sv
// Lowest-set-bit priority encoder over a fetch group's lane vector.
// mask_o has lanes 0..idx_o set (all zero when no request is set).
module lane_prio_enc #(
  parameter int unsigned W     = 4,
  parameter int unsigned IDX_W = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]     req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o,
  output logic [W-1:0]     mask_o
);

  logic below;

  // Scan upward: first set lane gives the index; prefix mask ends there.
  always_comb begin
    idx_o  = '0;
    any_o  = 1'b0;
    mask_o = '0;
    below  = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      mask_o[i] = ~below;
      if (!below && req_i[i]) begin
        idx_o = IDX_W'(i);
      end
      below = below | req_i[i];
    end
    any_o = below;
    if (!any_o) begin
      mask_o = '0;
    end
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Registered next-PC unit for the fetch stage. Priority: recovery, stall,
// jump, predicted-taken lane, branch-handler, sequential. A jump/bhndlr
// redirect arriving during a stall is buffered and applied on stall release.
// Optional build macro PC_STATS_EN adds saturating mispred_cnt/stall_cnt.
module fetch_pc_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned   PC_W     = 16,
  parameter int unsigned   FETCH_W  = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall_fetch,
  input  logic                    stall_for_jump,
  input  logic                    has_mispredict,
  input  logic [PC_W-1:0]         recovery_pc,
  input  logic                    jump_valid,
  input  logic [PC_W-1:0]         jump_pc,
  input  logic [FETCH_W-1:0]      pred_tkn,
  input  logic [FETCH_W*PC_W-1:0] pred_tgt,
  input  logic                    bhndlr_valid,
  input  logic [PC_W-1:0]         bhndlr_pc,
  output logic [PC_W-1:0]         pc,
  output logic [2:0]              pc_sel,
  output logic [FETCH_W-1:0]      lane_vld,
  output logic                    redir_pend
`ifdef PC_STATS_EN
  ,
  output logic [15:0]             mispred_cnt,
  output logic [15:0]             stall_cnt
`endif
);

  localparam int unsigned IDX_W = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [2:0]        sel_q, sel_d;
  logic [FETCH_W-1:0] lane_q, lane_d;
  logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
  logic [2:0]        pend_sel_q, pend_sel_d;

  logic              stall;
  logic [IDX_W-1:0]  enc_idx;
  logic              enc_any;
  logic [FETCH_W-1:0] enc_mask;
  logic [PC_W-1:0]   tgt_arr [FETCH_W];

  assign stall = stall_fetch | stall_for_jump;

  for (genvar g = 0; g < FETCH_W; g++) begin : g_tgt
    assign tgt_arr[g] = pred_tgt[g*PC_W +: PC_W];
  end

  lane_prio_enc #(
    .W     (FETCH_W),
    .IDX_W (IDX_W)
  ) u_prio (
    .req_i  (pred_tkn),
    .idx_o  (enc_idx),
    .any_o  (enc_any),
    .mask_o (enc_mask)
  );

  // State, PC, source code, lane mask and pending-redirect registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      pc_q       <= RESET_PC;
      sel_q      <= SEL_RST;
      lane_q     <= '0;
      pend_pc_q  <= '0;
      pend_sel_q <= SEL_JUMP;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      sel_q      <= sel_d;
      lane_q     <= lane_d;
      pend_pc_q  <= pend_pc_d;
      pend_sel_q <= pend_sel_d;
    end
  end

  // Next state and redirect buffering; oldest buffered request wins.
  always_comb begin
    state_d    = state_q;
    pend_pc_d  = pend_pc_q;
    pend_sel_d = pend_sel_q;
    if (has_mispredict) begin
      state_d   = ST_RUN;
      pend_pc_d = '0;
    end else begin
      unique case (state_q)
        ST_INIT: state_d = ST_RUN;
        ST_RUN: begin
          if (stall && (jump_valid || bhndlr_valid)) begin
            state_d    = ST_PEND;
            pend_pc_d  = jump_valid ? jump_pc : bhndlr_pc;
            pend_sel_d = jump_valid ? SEL_JUMP : SEL_BHNDLR;
          end
        end
        ST_PEND: begin
          if (!stall) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  // Next PC, its source code and the lane-valid mask of the new group.
  always_comb begin
    pc_d   = pc_q;
    sel_d  = sel_q;
    lane_d = lane_q;
    if (has_mispredict) begin
      pc_d   = recovery_pc;
      sel_d  = SEL_RECOV;
      lane_d = '1;
    end else begin
      unique case (state_q)
        ST_INIT: ;
        ST_RUN: begin
          if (stall) begin
            sel_d = SEL_HOLD;
          end else if (jump_valid) begin
            pc_d   = jump_pc;
            sel_d  = SEL_JUMP;
            lane_d = '1;
          end else if (enc_any) begin
            pc_d   = tgt_arr[enc_idx];
            sel_d  = SEL_PRED;
            lane_d = enc_mask;
          end else if (bhndlr_valid) begin
            pc_d   = bhndlr_pc;
            sel_d  = SEL_BHNDLR;
            lane_d = '1;
          end else begin
            pc_d   = pc_q + PC_W'(FETCH_W);
            sel_d  = SEL_SEQ;
            lane_d = '1;
          end
        end
        ST_PEND: begin
          if (stall) begin
            sel_d = SEL_HOLD;
          end else begin
            pc_d   = pend_pc_q;
            sel_d  = pend_sel_q;
            lane_d = '1;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs.
  always_comb begin
    pc         = pc_q;
    pc_sel     = sel_q;
    lane_vld   = lane_q;
    redir_pend = (state_q == ST_PEND);
  end

`ifdef PC_STATS_EN
  logic [15:0] mis_cnt_q, stl_cnt_q;

  // Saturating event counters for mispredict cycles and hold cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_cnt_q <= '0;
      stl_cnt_q <= '0;
    end else begin
      if (has_mispredict && (mis_cnt_q != '1)) mis_cnt_q <= mis_cnt_q + 16'd1;
      if ((sel_d == SEL_HOLD) && (stl_cnt_q != '1)) stl_cnt_q <= stl_cnt_q + 16'd1;
    end
  end

  assign mispred_cnt = mis_cnt_q;
  assign stall_cnt   = stl_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl (default parameters).
module tb_fetch_pc_ctrl;
  import fetch_pkg::*;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned FETCH_W = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    stall_fetch, stall_for_jump, has_mispredict;
  logic [PC_W-1:0]         recovery_pc, jump_pc, bhndlr_pc;
  logic                    jump_valid, bhndlr_valid;
  logic [FETCH_W-1:0]      pred_tkn;
  logic [FETCH_W*PC_W-1:0] pred_tgt;
  logic [PC_W-1:0]         pc;
  logic [2:0]              pc_sel;
  logic [FETCH_W-1:0]      lane_vld;
  logic                    redir_pend;
`ifdef PC_STATS_EN
  logic [15:0]             mispred_cnt, stall_cnt;
`endif

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  fetch_pc_ctrl #(
    .PC_W     (PC_W),
    .FETCH_W  (FETCH_W),
    .RESET_PC (16'h0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_fetch    (stall_fetch),
    .stall_for_jump (stall_for_jump),
    .has_mispredict (has_mispredict),
    .recovery_pc    (recovery_pc),
    .jump_valid     (jump_valid),
    .jump_pc        (jump_pc),
    .pred_tkn       (pred_tkn),
    .pred_tgt       (pred_tgt),
    .bhndlr_valid   (bhndlr_valid),
    .bhndlr_pc      (bhndlr_pc),
    .pc             (pc),
    .pc_sel         (pc_sel),
    .lane_vld       (lane_vld),
    .redir_pend     (redir_pend)
`ifdef PC_STATS_EN
    ,
    .mispred_cnt    (mispred_cnt),
    .stall_cnt      (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    stall_fetch    = 1'b0;
    stall_for_jump = 1'b0;
    has_mispredict = 1'b0;
    recovery_pc    = '0;
    jump_valid     = 1'b0;
    jump_pc        = '0;
    pred_tkn       = '0;
    pred_tgt       = '0;
    bhndlr_valid   = 1'b0;
    bhndlr_pc      = '0;
  endtask

  task automatic chk_out(input string tag, input logic [15:0] e_pc, input logic [2:0] e_sel,
                         input logic [3:0] e_lane, input logic e_pend);
    chk({tag, ".pc"},   32'(pc),         32'(e_pc));
    chk({tag, ".sel"},  32'(pc_sel),     32'(e_sel));
    chk({tag, ".lane"}, 32'(lane_vld),   32'(e_lane));
    chk({tag, ".pend"}, 32'(redir_pend), 32'(e_pend));
  endtask

  initial begin
    rst_n = 1'b0;
    clr_inputs();
    #12;
    chk_out("reset", 16'h0000, SEL_RST, 4'b0000, 1'b0);
    rst_n = 1'b1;

    step();  // INIT -> RUN, outputs unchanged
    chk_out("init", 16'h0000, SEL_RST, 4'b0000, 1'b0);
    step();
    chk_out("seq0", 16'h0004, SEL_SEQ, 4'b1111, 1'b0);

    // Predicted taken: lanes 1 and 2 set, lowest (lane 1) wins.
    pred_tkn = 4'b0110;
    pred_tgt[1*PC_W +: PC_W] = 16'h0040;
    pred_tgt[2*PC_W +: PC_W] = 16'h0080;
    step();
    chk_out("pred1", 16'h0040, SEL_PRED, 4'b0011, 1'b0);
    clr_inputs();

    // Stalled jump buffered; later bhndlr ignored.
    stall_fetch = 1'b1;
    jump_valid  = 1'b1;
    jump_pc     = 16'h0100;
    step();
    chk_out("pend_a", 16'h0040, SEL_HOLD, 4'b0011, 1'b1);
    step();
    step();
    jump_valid   = 1'b0;
    bhndlr_valid = 1'b1;
    bhndlr_pc    = 16'h0300;
    step();
    chk_out("pend_b", 16'h0040, SEL_HOLD, 4'b0011, 1'b1);
    stall_fetch = 1'b0;
    step();
    chk_out("pend_rel", 16'h0100, SEL_JUMP, 4'b1111, 1'b0);
    clr_inputs();
    step();
    chk_out("seq1", 16'h0104, SEL_SEQ, 4'b1111, 1'b0);

    // Mispredict + stall + jump in RUN.
    has_mispredict = 1'b1;
    recovery_pc    = 16'h0200;
    stall_for_jump = 1'b1;
    jump_valid     = 1'b1;
    jump_pc        = 16'h0500;
    step();
    chk_out("recov_a", 16'h0200, SEL_RECOV, 4'b1111, 1'b0);
    // Enter PEND, then mispredict clears it.
    has_mispredict = 1'b0;
    step();
    chk_out("pend_c", 16'h0200, SEL_HOLD, 4'b1111, 1'b1);
    has_mispredict = 1'b1;
    recovery_pc    = 16'h0240;
    step();
    chk_out("recov_b", 16'h0240, SEL_RECOV, 4'b1111, 1'b0);
    clr_inputs();
    step();
    chk_out("seq2", 16'h0244, SEL_SEQ, 4'b1111, 1'b0);

    // Branch handler alone.
    bhndlr_valid = 1'b1;
    bhndlr_pc    = 16'h0700;
    step();
    chk_out("bhndlr", 16'h0700, SEL_BHNDLR, 4'b1111, 1'b0);
    clr_inputs();

    // Taken lane 3: full mask.
    pred_tkn = 4'b1000;
    pred_tgt[3*PC_W +: PC_W] = 16'h0900;
    step();
    chk_out("pred3", 16'h0900, SEL_PRED, 4'b1111, 1'b0);
    clr_inputs();

    // Sequential wrap.
    jump_valid = 1'b1;
    jump_pc    = 16'hFFFC;
    step();
    chk_out("jmp_top", 16'hFFFC, SEL_JUMP, 4'b1111, 1'b0);
    clr_inputs();
    step();
    chk_out("wrap", 16'h0000, SEL_SEQ, 4'b1111, 1'b0);

    // Reset while in PEND.
    stall_fetch = 1'b1;
    jump_valid  = 1'b1;
    jump_pc     = 16'h0123;
    step();
    chk_out("pend_d", 16'h0000, SEL_HOLD, 4'b1111, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("rst_pend", 16'h0000, SEL_RST, 4'b0000, 1'b0);
    clr_inputs();
    stall_fetch = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step();  // INIT -> RUN
    chk_out("init2", 16'h0000, SEL_RST, 4'b0000, 1'b0);
    repeat (5) step();
    chk_out("stall5", 16'h0000, SEL_HOLD, 4'b0000, 1'b0);
`ifdef PC_STATS_EN
    chk("stall_cnt", 32'(stall_cnt), 32'd5);
    chk("mispred_cnt0", 32'(mispred_cnt), 32'd0);
`endif
    stall_fetch    = 1'b0;
    has_mispredict = 1'b1;
    recovery_pc    = 16'h0010;
    step();
    chk_out("recov_c", 16'h0010, SEL_RECOV, 4'b1111, 1'b0);
`ifdef PC_STATS_EN
    chk("mispred_cnt1", 32'(mispred_cnt), 32'd1);
    chk("stall_cnt_hold", 32'(stall_cnt), 32'd5);
`endif
    clr_inputs();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
